// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ Avalon-MM read requesters onto one
// shared read master and routes each in-order response back to the requester
// that issued it, using a FIFO of granted requester IDs.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   s_read/s_address/s_byteenable - per-requester read commands (packed by index)
//   s_waitrequest         - per-requester stall, low only on that requester's accept cycle
//   s_readdata            - response data broadcast to every requester
//   s_readdatavalid       - one-hot response strobe for the owning requester
//   avm_m0_*              - shared Avalon-MM read master
//   o_err                 - sticky: a response arrived with no read outstanding
module mem_read_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          s_read,
  input  logic [NUM_REQ*ADDR_W-1:0]   s_address,
  input  logic [NUM_REQ*2-1:0]        s_byteenable,
  output logic [NUM_REQ-1:0]          s_waitrequest,
  output logic [15:0]                 s_readdata,
  output logic [NUM_REQ-1:0]          s_readdatavalid,
  output logic                        avm_m0_read,
  output logic [ADDR_W-1:0]           avm_m0_address,
  output logic [1:0]                  avm_m0_byteenable,
  input  logic [15:0]                 avm_m0_readdata,
  input  logic                        avm_m0_readdatavalid,
  input  logic                        avm_m0_waitrequest,
  output logic                        o_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // ST_HOLD: a command is stalled by waitrequest, so the grant must not move.
  typedef enum logic {ST_ARB, ST_HOLD} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] hold_idx;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             accept;
  logic             pop;
  logic             rsp_orphan;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [IDX_W-1:0] id_mem [MAX_OUTSTANDING];
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] head_oh;

  // Occupancy from registered pointers only: a same-cycle pop cannot unblock issue.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // Grant selection, command issue and lock next-state.
  always_comb begin
    state_nxt = state;
    grant     = rr_ptr;
    cand      = '0;
    found     = 1'b0;
    if (state == ST_HOLD) begin
      grant = hold_idx;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
        if (!found && s_read[cand]) begin
          found = 1'b1;
          grant = cand;
        end
      end
    end
    avm_m0_read = s_read[grant] & ~fifo_full & ~reset;
    accept      = avm_m0_read & ~avm_m0_waitrequest;
    if (avm_m0_read && avm_m0_waitrequest) state_nxt = ST_HOLD;
    else                                   state_nxt = ST_ARB;
  end

  // Command mux and per-requester handshake.
  always_comb begin
    avm_m0_address    = s_address[32'(grant)*ADDR_W +: ADDR_W];
    avm_m0_byteenable = s_byteenable[32'(grant)*2 +: 2];
    grant_oh          = NUM_REQ'(1) << grant;
    s_waitrequest     = accept ? ~grant_oh : '1;
  end

  // Response routing to the oldest outstanding ID.
  always_comb begin
    pop             = avm_m0_readdatavalid & ~fifo_empty & ~reset;
    rsp_orphan      = avm_m0_readdatavalid & fifo_empty & ~reset;
    head_oh         = NUM_REQ'(1) << id_mem[rd_ptr[PTR_W-1:0]];
    s_readdatavalid = pop ? head_oh : '0;
    s_readdata      = avm_m0_readdata;
  end

  // State, round-robin pointer, FIFO pointers and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_ARB;
      rr_ptr   <= '0;
      hold_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_idx <= grant;
      if (accept) begin
        rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop)        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (rsp_orphan) o_err  <= 1'b1;
    end
  end

  // ID storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (accept) id_mem[wr_ptr[PTR_W-1:0]] <= grant;
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: expected requester IDs are queued as
// commands are accepted and popped when responses are driven back.
module tb_mem_read_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned MAX_OUT = 8;
  localparam int unsigned ADDR_W  = 32;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        s_read;
  logic [NUM_REQ*ADDR_W-1:0] s_address;
  logic [NUM_REQ*2-1:0]      s_byteenable;
  logic [NUM_REQ-1:0]        s_waitrequest;
  logic [15:0]               s_readdata;
  logic [NUM_REQ-1:0]        s_readdatavalid;
  logic                      avm_m0_read;
  logic [ADDR_W-1:0]         avm_m0_address;
  logic [1:0]                avm_m0_byteenable;
  logic [15:0]               avm_m0_readdata;
  logic                      avm_m0_readdatavalid;
  logic                      avm_m0_waitrequest;
  logic                      o_err;

  int          errors = 0;
  int          checks = 0;
  int          exp_q[$];
  logic [15:0] next_data = 16'hA000;

  mem_read_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .s_read(s_read), .s_address(s_address), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .avm_m0_read(avm_m0_read), .avm_m0_address(avm_m0_address),
    .avm_m0_byteenable(avm_m0_byteenable), .avm_m0_readdata(avm_m0_readdata),
    .avm_m0_readdatavalid(avm_m0_readdatavalid),
    .avm_m0_waitrequest(avm_m0_waitrequest), .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] addr_of(input int i);
    case (i)
      0:       addr_of = 32'h0000_0040;
      1:       addr_of = 32'h0000_0020;
      2:       addr_of = 32'h0000_0010;
      default: addr_of = 32'h0000_0080;
    endcase
  endfunction

  function automatic logic [1:0] be_of(input int i);
    case (i)
      0:       be_of = 2'b01;
      1:       be_of = 2'b10;
      2:       be_of = 2'b11;
      default: be_of = 2'b01;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, let combinational outputs settle.
  task automatic cyc(input logic [3:0] rd, input logic wr, input logic rdv, input logic [15:0] d);
    @(negedge clk);
    s_read               = rd;
    avm_m0_waitrequest   = wr;
    avm_m0_readdatavalid = rdv;
    avm_m0_readdata      = d;
    #1;
  endtask

  // g >= 0: expect requester g accepted this cycle; g < 0: expect no issue.
  // rsp: drive a response and expect it routed to the oldest queued ID.
  task automatic step(input logic [3:0] rd, input int g, input bit rsp, input string tag);
    logic [15:0] d;
    logic [3:0]  oh;
    logic [3:0]  wexp;
    int          h;
    d = next_data;
    if (rsp) next_data = next_data + 16'h0101;
    cyc(rd, 1'b0, rsp, d);
    if (g < 0) begin
      check({tag, "_read"}, {31'h0, avm_m0_read}, 32'h0);
      check({tag, "_wreq"}, {28'h0, s_waitrequest}, 32'hF);
    end else begin
      oh   = 4'b0001 << g;
      wexp = ~oh;
      check({tag, "_read"}, {31'h0, avm_m0_read}, 32'h1);
      check({tag, "_addr"}, avm_m0_address, addr_of(g));
      check({tag, "_be"}, {30'h0, avm_m0_byteenable}, {30'h0, be_of(g)});
      check({tag, "_wreq"}, {28'h0, s_waitrequest}, {28'h0, wexp});
    end
    if (rsp) begin
      if (exp_q.size() == 0) begin
        check({tag, "_orphan_valid"}, {28'h0, s_readdatavalid}, 32'h0);
      end else begin
        h  = exp_q.pop_front();
        oh = 4'b0001 << h;
        check({tag, "_rvalid"}, {28'h0, s_readdatavalid}, {28'h0, oh});
        check({tag, "_rdata"}, {16'h0, s_readdata}, {16'h0, d});
      end
    end
    if (g >= 0) exp_q.push_back(g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset                = 1'b1;
    s_read               = '0;
    avm_m0_readdatavalid = 1'b0;
    avm_m0_waitrequest   = 1'b0;
    @(negedge clk);
    #1;
    exp_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    s_address    = {addr_of(3), addr_of(2), addr_of(1), addr_of(0)};
    s_byteenable = {be_of(3), be_of(2), be_of(1), be_of(0)};
    avm_m0_readdata = 16'h0;

    // Outputs held inactive during reset even with live requests and responses.
    @(negedge clk);
    reset = 1'b1; s_read = 4'hF; avm_m0_readdatavalid = 1'b1; avm_m0_waitrequest = 1'b0;
    @(negedge clk);
    #1;
    check("rst_read", {31'h0, avm_m0_read}, 32'h0);
    check("rst_wreq", {28'h0, s_waitrequest}, 32'hF);
    check("rst_rvalid", {28'h0, s_readdatavalid}, 32'h0);
    check("rst_err", {31'h0, o_err}, 32'h0);
    do_reset();

    // Single requester, response two cycles after acceptance.
    step(4'b0100, 2, 1'b0, "r29_issue");
    step(4'b0000, -1, 1'b0, "r29_gap");
    next_data = 16'hBEEF;
    step(4'b0000, -1, 1'b1, "r29_rsp");
    // Idle cycles leave rr_ptr at 3.
    step(4'b0000, -1, 1'b0, "r25_idle0");
    step(4'b0000, -1, 1'b0, "r25_idle1");
    step(4'b1111, 3, 1'b0, "r25_next");
    step(4'b0000, -1, 1'b1, "r25_rsp");

    // All four requesting continuously.
    do_reset();
    step(4'b1111, 0, 1'b0, "r30_g0");
    step(4'b1111, 1, 1'b0, "r30_g1");
    step(4'b1111, 2, 1'b0, "r30_g2");
    step(4'b1111, 3, 1'b0, "r30_g3");
    step(4'b1111, 0, 1'b0, "r30_g4");
    for (int i = 0; i < 5; i++) step(4'b0000, -1, 1'b1, "r30_rsp");

    // Waitrequest stall: grant locked on requester 1 even when 0 arrives.
    do_reset();
    cyc(4'b1010, 1'b1, 1'b0, 16'h0);
    check("r31_c1_read", {31'h0, avm_m0_read}, 32'h1);
    check("r31_c1_addr", avm_m0_address, addr_of(1));
    check("r31_c1_wreq", {28'h0, s_waitrequest}, 32'hF);
    cyc(4'b1011, 1'b1, 1'b0, 16'h0);
    check("r31_c2_addr", avm_m0_address, addr_of(1));
    check("r31_c2_wreq", {28'h0, s_waitrequest}, 32'hF);
    cyc(4'b1011, 1'b1, 1'b0, 16'h0);
    check("r31_c3_addr", avm_m0_address, addr_of(1));
    check("r31_c3_be", {30'h0, avm_m0_byteenable}, {30'h0, be_of(1)});
    step(4'b1011, 1, 1'b0, "r31_c4_accept");
    step(4'b1001, 3, 1'b0, "r31_next3");
    step(4'b0001, 0, 1'b0, "r31_next0");
    for (int i = 0; i < 3; i++) step(4'b0000, -1, 1'b1, "r31_rsp");

    // Fill the ID FIFO, stall, pop releases issue only on the following cycle.
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b1111, i % 4, 1'b0, "r32_fill");
    step(4'b1111, -1, 1'b0, "r32_full");
    step(4'b1111, -1, 1'b1, "r32_full_pop");
    step(4'b1111, 0, 1'b0, "r32_resume");
    for (int i = 0; i < 8; i++) step(4'b0000, -1, 1'b1, "r32_drain");

    // Simultaneous push and pop at occupancy 5.
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b1111, i % 4, 1'b0, "r34_fill");
    step(4'b1111, 1, 1'b1, "r34_pushpop");
    step(4'b1111, 2, 1'b0, "r34_top6");
    step(4'b1111, 3, 1'b0, "r34_top7");
    step(4'b1111, 0, 1'b0, "r34_top8");
    step(4'b1111, -1, 1'b0, "r34_full");
    for (int i = 0; i < 8; i++) step(4'b0000, -1, 1'b1, "r34_drain");

    // Orphan response sets a sticky error.
    do_reset();
    step(4'b0000, -1, 1'b1, "r33_orphan");
    cyc(4'b0000, 1'b0, 1'b0, 16'h0);
    check("r33_err_set", {31'h0, o_err}, 32'h1);
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0, 1'b0, 16'h0);
    check("r33_err_hold", {31'h0, o_err}, 32'h1);
    step(4'b0001, 0, 1'b0, "r33_issue");
    step(4'b0000, -1, 1'b1, "r33_rsp");
    check("r33_err_still", {31'h0, o_err}, 32'h1);
    do_reset();
    check("r33_err_clr", {31'h0, o_err}, 32'h0);

    // Reset with a read outstanding discards its ID.
    step(4'b0100, 2, 1'b0, "r28_issue");
    do_reset();
    step(4'b0000, -1, 1'b1, "r28_stale");
    cyc(4'b0000, 1'b0, 1'b0, 16'h0);
    check("r28_err", {31'h0, o_err}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
